// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg -- shared definitions for the EX-stage multiply/divide unit.
//   ALU_OP_W / aluop_t : width and type of the ID/EX operation code bus
//   EXE_*_OP           : operation codes decoded by ex_muldiv
//   div_state_e        : divider FSM state encoding (also exported for debug)
package ex_muldiv_pkg;

  localparam int ALU_OP_W = 8;
  typedef logic [ALU_OP_W-1:0] aluop_t;

  localparam aluop_t EXE_NOP_OP   = 8'b0000_0000;
  localparam aluop_t EXE_MULT_OP  = 8'b0001_1000;
  localparam aluop_t EXE_MULTU_OP = 8'b0001_1001;
  localparam aluop_t EXE_DIV_OP   = 8'b0001_1010;
  localparam aluop_t EXE_DIVU_OP  = 8'b0001_1011;
  localparam aluop_t EXE_MADD_OP  = 8'b1010_0110;
  localparam aluop_t EXE_MADDU_OP = 8'b1010_1000;
  localparam aluop_t EXE_MSUB_OP  = 8'b1010_1010;
  localparam aluop_t EXE_MSUBU_OP = 8'b1010_1011;

  typedef enum logic [1:0] {
    S_IDLE       = 2'b00,
    S_DIV_BYZERO = 2'b01,
    S_DIV_ON     = 2'b10,
    S_DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/ex_muldiv_div.sv
// mdu_div -- iterative restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start_i           : a DIV/DIVU is presented; accepted only in S_IDLE
//   signed_i          : treat operands as two's complement
//   op_a_i, op_b_i    : dividend, divisor (sampled in the accepting cycle)
//   annul_i           : abort any operation in flight, back to S_IDLE
//   result_o          : {remainder, quotient}, valid while ready_o=1
//   ready_o           : result valid this cycle (S_DIV_END or S_DIV_BYZERO)
//   state_o           : current FSM state (debug)
module mdu_div
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   op_a_i,
  input  logic [WIDTH-1:0]   op_b_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output div_state_e         state_o
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend magnitude, shifts into quotient
  logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, diff;
  logic             q_bit;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign a_neg = signed_i & op_a_i[WIDTH-1];
  assign b_neg = signed_i & op_b_i[WIDTH-1];
  assign a_mag = a_neg ? -op_a_i : op_a_i;
  assign b_mag = b_neg ? -op_b_i : op_b_i;

  // Bring down the next dividend bit and trial-subtract. The remainder is
  // always below the divisor, so the shifted value fits in WIDTH+1 bits and
  // the top bit of the difference is a clean borrow flag.
  assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign q_bit  = ~diff[WIDTH];

  // Quotient takes the XOR of the signs, remainder follows the dividend.
  // 0x80000000 / -1 wraps back to 0x80000000 on negation, remainder 0.
  assign quot_fix = neg_quot_q ? -dvd_q : dvd_q;
  assign rem_fix  = neg_rem_q  ? -rem_q : rem_q;

  assign state_o = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    ready_o    = 1'b0;
    result_o   = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (op_b_i == '0) begin
            state_d = S_DIV_BYZERO;
          end else begin
            dvd_d      = a_mag;
            dvs_d      = b_mag;
            rem_d      = '0;
            cnt_d      = '0;
            neg_quot_d = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            state_d    = S_DIV_ON;
          end
        end
      end
      S_DIV_ON: begin
        rem_d = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], q_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = S_DIV_END;
        end
      end
      // Divide by zero completes after a single stall cycle: the zero
      // result is presented here and the FSM goes straight back to idle.
      S_DIV_BYZERO: begin
        ready_o  = 1'b1;
        result_o = '0;
        state_d  = S_IDLE;
      end
      S_DIV_END: begin
        ready_o  = 1'b1;
        result_o = {rem_fix, quot_fix};
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (annul_i) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      ready_o  = 1'b0;
      result_o = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv -- EX-stage multiply / divide / multiply-accumulate unit.
// Build option: define MDU_MADD_EN to include MADD/MADDU/MSUB/MSUBU and their
// accumulate register; without it those opcodes decode as unrecognised.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   flush              : exception flush, aborts anything in flight
//   aluop_i            : operation code from ID/EX
//   reg1_i, reg2_i     : operands rs, rt
//   hi_i, lo_i         : forwarded HI/LO (accumulate source)
//   stall_req_o        : pipeline stall request
//   whilo_o            : HI/LO write enable
//   hi_o, lo_o         : HI/LO write data
//   dbg_div_state_o    : divider FSM state (debug)
//
// Handshake: the pipeline holds aluop_i and operands stable while
// stall_req_o=1. The cycle with stall_req_o=0 and whilo_o=1 is the single
// completion cycle carrying the HI/LO write; whilo_o is never high together
// with stall_req_o. flush and rst force both low in the same cycle.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [ALU_OP_W-1:0] aluop_i,
  input  logic [WIDTH-1:0]    reg1_i,
  input  logic [WIDTH-1:0]    reg2_i,
  input  logic [WIDTH-1:0]    hi_i,
  input  logic [WIDTH-1:0]    lo_i,
  output logic                stall_req_o,
  output logic                whilo_o,
  output logic [WIDTH-1:0]    hi_o,
  output logic [WIDTH-1:0]    lo_o,
  output div_state_e          dbg_div_state_o
);

  logic               is_mult_s, is_mult_u, is_mult_any;
  logic               is_div_s, is_div_any;
  logic               use_signed;
  logic [2*WIDTH-1:0] prod_s, prod_u, prod;
  logic [2*WIDTH-1:0] div_result;
  logic               div_ready;
  div_state_e         div_state;

  assign is_mult_s   = (aluop_i == EXE_MULT_OP);
  assign is_mult_u   = (aluop_i == EXE_MULTU_OP);
  assign is_mult_any = is_mult_s | is_mult_u;
  assign is_div_s    = (aluop_i == EXE_DIV_OP);
  assign is_div_any  = is_div_s | (aluop_i == EXE_DIVU_OP);

  // Both products are formed at full 2*WIDTH width; sign-extending the
  // operands makes the low half of the unsigned multiply the signed product.
  assign prod_s = {{WIDTH{reg1_i[WIDTH-1]}}, reg1_i} * {{WIDTH{reg2_i[WIDTH-1]}}, reg2_i};
  assign prod_u = {{WIDTH{1'b0}}, reg1_i} * {{WIDTH{1'b0}}, reg2_i};
  assign prod   = use_signed ? prod_s : prod_u;

  mdu_div #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start_i  (is_div_any & ~flush),
    .signed_i (is_div_s),
    .op_a_i   (reg1_i),
    .op_b_i   (reg2_i),
    .annul_i  (flush),
    .result_o (div_result),
    .ready_o  (div_ready),
    .state_o  (div_state)
  );

  assign dbg_div_state_o = div_state;

`ifdef MDU_MADD_EN
  logic               is_madd_s, is_madd_any, is_msub;
  logic               phase_q, phase_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  assign is_madd_s   = (aluop_i == EXE_MADD_OP) | (aluop_i == EXE_MSUB_OP);
  assign is_msub     = (aluop_i == EXE_MSUB_OP) | (aluop_i == EXE_MSUBU_OP);
  assign is_madd_any = is_madd_s | is_msub | (aluop_i == EXE_MADDU_OP);
  assign use_signed  = is_mult_s | is_madd_s;
`else
  assign use_signed  = is_mult_s;
  // HI/LO inputs only feed the accumulate path.
  logic unused_hilo;
  assign unused_hilo = ^{hi_i, lo_i};
`endif

  always_comb begin
    stall_req_o = 1'b0;
    whilo_o     = 1'b0;
    hi_o        = '0;
    lo_o        = '0;
`ifdef MDU_MADD_EN
    phase_d     = phase_q;
    acc_d       = acc_q;
`endif

    // A running division owns the unit regardless of aluop_i.
    if (div_ready) begin
      whilo_o      = 1'b1;
      {hi_o, lo_o} = div_result;
    end else if (div_state == S_DIV_ON || (div_state == S_IDLE && is_div_any)) begin
      stall_req_o = 1'b1;
    end else if (is_mult_any) begin
      whilo_o      = 1'b1;
      {hi_o, lo_o} = prod;
    end
`ifdef MDU_MADD_EN
    else if (is_madd_any) begin
      if (!phase_q) begin
        stall_req_o = 1'b1;
        acc_d       = is_msub ? -prod : prod;
        phase_d     = 1'b1;
      end else begin
        whilo_o      = 1'b1;
        {hi_o, lo_o} = {hi_i, lo_i} + acc_q;
        phase_d      = 1'b0;
      end
    end
    if (!is_madd_any) begin
      phase_d = 1'b0;
    end
`endif

    if (flush || rst) begin
      stall_req_o = 1'b0;
      whilo_o     = 1'b0;
      hi_o        = '0;
      lo_o        = '0;
`ifdef MDU_MADD_EN
      phase_d     = 1'b0;
`endif
    end
  end

`ifdef MDU_MADD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      phase_q <= phase_d;
      acc_q   <= acc_d;
    end
  end
`endif

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  aluop_t      aluop;
  logic [31:0] reg1, reg2, hi_in, lo_in;
  logic        stall_req, whilo;
  logic [31:0] hi_out, lo_out;
  div_state_e  dbg_state;

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .aluop_i         (aluop),
    .reg1_i          (reg1),
    .reg2_i          (reg2),
    .hi_i            (hi_in),
    .lo_i            (lo_in),
    .stall_req_o     (stall_req),
    .whilo_o         (whilo),
    .hi_o            (hi_out),
    .lo_o            (lo_out),
    .dbg_div_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every HI/LO write must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (whilo === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got hi=0x%0h lo=0x%0h, expected no write", hi_out, lo_out);
        end else begin
          check("hilo_write", {hi_out, lo_out}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Presents one operation, holds it while stalled, checks the stall length
  // and that the expected write (if any) was consumed by the monitor.
  task automatic run_op(input string name, input aluop_t op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] h, input logic [31:0] l,
                        input int exp_stall, input bit exp_write,
                        input logic [63:0] exp_val);
    int n;
    bit done;
    aluop = op; reg1 = a; reg2 = b; hi_in = h; lo_in = l;
    if (exp_write) exp_q.push_back(exp_val);
    n = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (stall_req === 1'b1) begin
        n++;
        if (n > 100) begin
          checks++;
          errors++;
          $display("FAIL %s_timeout: got stall still high after %0d cycles, expected release", name, n);
          done = 1;
        end
      end else begin
        done = 1;
      end
    end
    check({name, "_stall"}, 64'(n), 64'(exp_stall));
    @(posedge clk); #1;
    aluop = EXE_NOP_OP;
    check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; flush = 1'b0;
    // A live MULT during reset must still be masked.
    aluop = EXE_MULT_OP; reg1 = 32'd6; reg2 = 32'd7; hi_in = '0; lo_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_whilo", 64'(whilo), 64'd0);
    check("rst_hilo", {hi_out, lo_out}, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    // Unrecognised opcode
    aluop = 8'h20; reg1 = 32'd5; reg2 = 32'd7; hi_in = 32'h1234; lo_in = 32'h5678;
    @(negedge clk);
    check("unrec_stall", 64'(stall_req), 64'd0);
    check("unrec_whilo", 64'(whilo), 64'd0);
    check("unrec_hilo", {hi_out, lo_out}, 64'd0);
    @(posedge clk); #1;

    // Multiplies
    run_op("mult_m1x2",  EXE_MULT_OP,  32'hFFFFFFFF, 32'd2, 0, 0, 0, 1, 64'hFFFFFFFF_FFFFFFFE);
    run_op("multu_m1x2", EXE_MULTU_OP, 32'hFFFFFFFF, 32'd2, 0, 0, 0, 1, 64'h00000001_FFFFFFFE);
    run_op("mult_max",   EXE_MULT_OP,  32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 0, 1, 64'h3FFFFFFF_00000001);
    run_op("mult_neg",   EXE_MULT_OP,  32'hFFFFFFFD, 32'd5, 0, 0, 0, 1, 64'hFFFFFFFF_FFFFFFF1);

    // Divides: 33 stall cycles, then {rem, quot}
    run_op("div_7_m2",    EXE_DIV_OP,  32'd7, 32'hFFFFFFFE, 0, 0, 33, 1, {32'h1, 32'hFFFFFFFD});
    run_op("div_min_m1",  EXE_DIV_OP,  32'h80000000, 32'hFFFFFFFF, 0, 0, 33, 1, {32'h0, 32'h80000000});
    run_op("div_m7_2",    EXE_DIV_OP,  32'hFFFFFFF9, 32'd2, 0, 0, 33, 1, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("divu_big",    EXE_DIVU_OP, 32'hFFFFFFFF, 32'd16, 0, 0, 33, 1, {32'hF, 32'h0FFFFFFF});
    run_op("divu_100_7",  EXE_DIVU_OP, 32'd100, 32'd7, 0, 0, 33, 1, {32'd2, 32'd14});
    run_op("divu_10_0",   EXE_DIVU_OP, 32'd10, 32'd0, 0, 0, 1, 1, 64'd0);
    run_op("div_m5_0",    EXE_DIV_OP,  32'hFFFFFFFB, 32'd0, 0, 0, 1, 1, 64'd0);

    // Multiply-accumulate (back to back)
`ifdef MDU_MADD_EN
    run_op("madd_3x4",   EXE_MADD_OP,  32'd3, 32'd4, 32'd0, 32'd5, 1, 1, 64'd17);
    run_op("msub_3x4",   EXE_MSUB_OP,  32'd3, 32'd4, 32'd0, 32'd5, 1, 1, 64'hFFFFFFFF_FFFFFFF9);
    run_op("maddu_big",  EXE_MADDU_OP, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFF, 1, 1, 64'h00000003_FFFFFFFD);
    run_op("msubu_2x3",  EXE_MSUBU_OP, 32'd2, 32'd3, 32'd0, 32'd10, 1, 1, 64'd4);
    run_op("madd_neg",   EXE_MADD_OP,  32'hFFFFFFFF, 32'd3, 32'd0, 32'd5, 1, 1, 64'd2);
`else
    run_op("madd_3x4",   EXE_MADD_OP,  32'd3, 32'd4, 32'd0, 32'd5, 0, 0, 64'd0);
    run_op("msubu_2x3",  EXE_MSUBU_OP, 32'd2, 32'd3, 32'd0, 32'd10, 0, 0, 64'd0);
`endif

    // Flush at cycle 10 of a DIV
    aluop = EXE_DIV_OP; reg1 = 32'd100; reg2 = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) begin
        @(negedge clk);
        check("flush_pre_stall", 64'(stall_req), 64'd1);
      end
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall", 64'(stall_req), 64'd0);
    check("flush_whilo", 64'(whilo), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; aluop = EXE_NOP_OP;
    @(negedge clk);
    check("flush_state", 64'(dbg_state), 64'(S_IDLE));
    check("flush_post_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;

    // Reset during DIV_ON, then a clean DIVU
    aluop = EXE_DIV_OP; reg1 = 32'd1000; reg2 = 32'd3;
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rston_state", 64'(dbg_state), 64'(S_DIV_ON));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rston_stall", 64'(stall_req), 64'd0);
    check("rston_whilo", 64'(whilo), 64'd0);
    check("rston_hilo", {hi_out, lo_out}, 64'd0);
    check("rston_state_after", 64'(dbg_state), 64'(S_IDLE));
    rst = 1'b0; aluop = EXE_NOP_OP;
    @(posedge clk); #1;
    run_op("divu_9_3", EXE_DIVU_OP, 32'd9, 32'd3, 0, 0, 33, 1, {32'd0, 32'd3});

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    checks++;
    errors++;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
